fifo_uart_tx: RTL and testbench

- Drain stage that sits directly downstream of the 8x8 synchronous FIFO.
- Pops one byte at a time through the FIFO read port and serialises it as an asynchronous UART frame on `tx`.
- Frame format: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- The FIFO read port has registered data: `data_out` updates on the clock edge at which `read_en` is sampled.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/fifo_uart_tx.sv | 146 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last clk cycle of each CLKS_PER_BIT period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-read FIFO and sends them as 8N1 UART frames.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic              tx_q, tx_d;
    logic              rd_en_q, rd_en_d;
    logic              baud_clr;
    logic              tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        baud_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_clr = 1'b1;
                if (!fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            // fifo_empty is not rechecked here: only our own pop can drain the FIFO
            ST_FETCH: begin
                baud_clr = 1'b1;
                state_d  = ST_LATCH;
            end
            ST_LATCH: begin
                baud_clr = 1'b1;
                shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_data;
`endif
                state_d  = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // tx and rd_en are registered from the state being entered
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
        rd_en_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            tx_q     <= UART_IDLE_LEVEL;
            rd_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = rd_en_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO plus a frame-level reference of the UART line.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    int push_cnt  = 0;
    int pop_cnt   = 0;
    int underflow = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // FIFO with registered read data
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (push_cnt == pop_cnt) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[pop_cnt[7:0]];
                pop_cnt   <= pop_cnt + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[push_cnt[7:0]] = b;
        push_cnt = push_cnt + 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic calc_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return logic'(ones % 2);
    endfunction

    // Line level expected in bit period k of a frame carrying d
    function automatic logic exp_bit(input logic [7:0] d, input logic par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return par;
        return 1'b1;
    endfunction

    // Counts idle-high samples before the first start-bit sample (bounded)
    task automatic wait_start(output int gap, output bit found);
        gap   = 0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
    endtask

    task automatic send_check(input logic [7:0] d, input logic par, input int exp_gap);
        int gap;
        bit found;
        int bad;
        int fd_cnt;
        int fd_pos;
        wait_start(gap, found);
        chk($sformatf("start_found_%02h", d), int'(found), 1);
        if (found) begin
            chk($sformatf("gap_%02h", d), gap, exp_gap);
            fd_cnt = 0;
            fd_pos = -1;
            for (int k = 0; k < NB; k++) begin
                bad = 0;
                for (int c = 0; c < CPB; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    if (tx !== exp_bit(d, par, k)) bad++;
                    if (busy !== 1'b1) bad++;
                    if (frame_done === 1'b1) begin
                        fd_cnt++;
                        fd_pos = k * CPB + c;
                    end
                end
                chk($sformatf("frame_%02h_bit%0d_bad_samples", d, k), bad, 0);
            end
            chk($sformatf("frame_done_cnt_%02h", d), fd_cnt, 1);
            chk($sformatf("frame_done_pos_%02h", d), fd_pos, NB * CPB - 1);
        end
    endtask

    task automatic idle_check(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        vec_t       tbl [7];
        vec_t       fill [7];
        logic [7:0] rnd_q [$];
        logic [7:0] b;
        int         p0;
        int         gap;
        bit         found;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h03, 1'b0};
        tbl[3] = '{8'h00, 1'b0};
        tbl[4] = '{8'hFF, 1'b0};
        tbl[5] = '{8'h3C, 1'b0};
        tbl[6] = '{8'h80, 1'b1};
        fill[0] = '{8'h01, 1'b1};
        fill[1] = '{8'h02, 1'b1};
        fill[2] = '{8'h03, 1'b0};
        fill[3] = '{8'h04, 1'b1};
        fill[4] = '{8'h05, 1'b0};
        fill[5] = '{8'h06, 1'b0};
        fill[6] = '{8'h07, 1'b1};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rd_en", int'(fifo_rd_en), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        reset = 1'b0;
        idle_check("idle_after_reset_100", 100);

        // single frames from an empty FIFO
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("busy_idle_before_%02h", tbl[i].data), int'(busy), 0);
            p0 = pop_cnt;
            push(tbl[i].data);
            send_check(tbl[i].data, tbl[i].par, 2);
            chk($sformatf("pops_%02h", tbl[i].data), pop_cnt - p0, 1);
        end

        // back-to-back frames
        @(negedge clk);
        p0 = pop_cnt;
        push(8'h00);
        push(8'hFF);
        send_check(8'h00, 1'b0, 2);
        send_check(8'hFF, 1'b0, 3);
        chk("b2b_pops", pop_cnt - p0, 2);
        @(negedge clk);
        chk("b2b_fifo_empty", int'(fifo_empty), 1);
        chk("b2b_busy_low", int'(busy), 0);

        // reset in the middle of data bit 3 of 0x3C
        push(8'h3C);
        wait_start(gap, found);
        chk("rst_mid_start_found", int'(found), 1);
        repeat (CPB * 4 + 1) @(negedge clk);
        chk("rst_mid_pre_bit3", int'(tx), 1);
        chk("rst_mid_pre_busy", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_tx", int'(tx), 1);
        chk("rst_mid_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pop_cnt;
        idle_check("rst_mid_idle_after", 60);
        chk("rst_mid_no_pops", pop_cnt - p0, 0);

        // reset during the start bit forces the line high at once
        push(8'h55);
        wait_start(gap, found);
        chk("rst_start_found", int'(found), 1);
        chk("rst_start_tx_low", int'(tx), 0);
        #1 reset = 1'b1;
        #1;
        chk("rst_start_tx_high", int'(tx), 1);
        @(negedge clk);
        reset = 1'b0;
        idle_check("rst_start_idle_after", 20);

        // full FIFO drained in order
        @(negedge clk);
        p0 = pop_cnt;
        for (int i = 0; i < 7; i++) push(fill[i].data);
        for (int i = 0; i < 7; i++) send_check(fill[i].data, fill[i].par, (i == 0) ? 2 : 3);
        chk("fill_pops", pop_cnt - p0, 7);
        @(negedge clk);
        chk("fill_busy_low", int'(busy), 0);
        idle_check("fill_idle_after", 10);

        // random burst against the queue reference
        @(negedge clk);
        p0 = pop_cnt;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            rnd_q.push_back(b);
            push(b);
        end
        for (int i = 0; i < 6; i++) begin
            b = rnd_q.pop_front();
            send_check(b, calc_parity(b), (i == 0) ? 2 : 3);
        end
        chk("rand_pops", pop_cnt - p0, 6);
        idle_check("rand_idle_after", 10);
        chk("no_underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
